bram_dp_param: RTL and testbench
================================

# bram_dp_param

Parametrised simple-dual-port block RAM for the NTT datapath: one write port with read-back, one independent read port. It generalises the fixed 18×4096 coefficient RAM with configurable width and depth, selectable collision semantics and an optional output register stage. It also has a built-in clear engine that zero-fills the array after reset or on request. It sits between the butterfly units and the coefficient/twiddle address generators.

## Interface
Parameters:
- `DW`, 18, data width in bits.
- `AW`, 12, address width; depth is `DEPTH = 2**AW` words.
- `RD_MODE`, 0, same-address write/read collision rule: 0 = write-first (new data), 1 = read-first (old data).
- `OREG`, 0, 1 adds one output register stage to both data outputs and to `rd_valid`.
- `CLR_ON_RST`, 1, 1 starts a clear sweep automatically when reset is released.
- `CLR_VAL`, 0, `DW`-bit word written by the clear engine.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clr_start`  in  1  one-cycle request to start a clear sweep.
- `clr_busy`  out  1  high while a clear sweep is in progress.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  AW  write and read-back address.
- `wr_din`  in  DW  write data.
- `wr_dout`  out  DW  read-back word at `wr_addr`.
- `rd_en`  in  1  read strobe.
- `rd_addr`  in  AW  read address.
- `rd_dout`  out  DW  read data.
- `rd_valid`  out  1  `rd_dout` holds data from an accepted read.

## Operation
- FSM states are IDLE and CLEAR. A counter `cnt` of width AW steps through addresses during a sweep.
- Reset: the FSM goes to CLEAR with `cnt=0` when `CLR_ON_RST=1`, and to IDLE otherwise. `wr_dout`, `rd_dout` and every pipeline register reset to 0. `rd_valid` resets to 0. `clr_busy` resets to `CLR_ON_RST`. Array contents are not reset.
- IDLE to CLEAR: on an edge with `clr_start=1` and `rst=0`, set `cnt=0`.
- CLEAR: each edge writes `ram[cnt]=CLR_VAL` and increments `cnt`. The edge that writes `DEPTH-1` moves the FSM to IDLE.
- While in CLEAR:
  - `clr_start` is ignored.
  - External writes are dropped.
  - `rd_en` is treated as 0.
- IDLE writes: on an edge with `wr_en=1`, set `ram[wr_addr]=wr_din`.
- Write-port read-back, every IDLE edge: sample `wr_addr` into the `wr_dout` path.
  - If `wr_en=1` in write-first mode (`RD_MODE=0`), the sample is `wr_din`.
  - Otherwise the sample is the old contents of `ram[wr_addr]`.
- Read port, IDLE edge with `rd_en=1`: sample `ram[rd_addr]`.
  - If `wr_en=1` and `wr_addr==rd_addr` on the same edge, the sample is `wr_din` when `RD_MODE=0` and the old word when `RD_MODE=1`.
  - With `rd_en=0`, the `rd_dout` path holds its last value.
- `rd_valid` pipeline: on each edge `rd_valid` loads `rd_en & IDLE`, so it is 0 on every read slot during a sweep.
- `OREG=1` pipeline: each of `wr_dout`, `rd_dout` and `rd_valid` passes through one extra register. That register loads every cycle (no hold gating on the extra stage), and the values are carried through unchanged.
- Arithmetic: `cnt` increments with wrap to 0, and the increment at `DEPTH-1` coincides with the exit from CLEAR. Addresses are never out of range because `DEPTH` equals `2**AW` exactly.

## Timing
- Read latency is `1+OREG` cycles: address and enable at edge N, data and `rd_valid` visible after edge `N+OREG`. Write read-back latency is also `1+OREG`.
- Throughput: one write and one read every cycle, no stalls in IDLE.
- Write-to-read visibility at different addresses is 1 edge: a read issued on the edge after the write returns the new data.
- A clear sweep lasts exactly `DEPTH` cycles with `clr_busy=1`. `clr_busy` rises on the edge that samples `clr_start` and falls on the edge that writes `DEPTH-1`. External accesses resume on the next edge.
- Reset asserted mid-sweep: the sweep restarts from `cnt=0` (with `CLR_ON_RST=1`) or aborts to IDLE (with `CLR_ON_RST=0`). Locations already cleared keep `CLR_VAL`.
- `clr_start` asserted together with `rst`: reset wins.

## Test plan
- Reset then clear, with AW=4, CLR_ON_RST=1, CLR_VAL=18'h0: `clr_busy` is high for 16 cycles after `rst` drops. Reading addresses 0..15 afterwards returns 0 with `rd_valid=1` one cycle later.
- Back-to-back traffic, OREG=0: write 0x155AA to addr 3, then read addr 3 on the next cycle. `rd_dout=0x155AA` and `rd_valid=1` one edge after the read.
- Same-address collision on addr 7, old word 0x00011, writing 0x3FFFF while reading: `rd_dout` and `wr_dout` show 0x3FFFF with RD_MODE=0 and 0x00011 with RD_MODE=1.
- OREG=1, reads to addrs 1,2,3 on consecutive cycles: data and `rd_valid` arrive 2 cycles after each request, in order, without gaps.
- `clr_start` mid-traffic: a write issued during the sweep is dropped (addr reads 0 after the sweep) and `rd_valid` stays 0 during the sweep. A second `clr_start` during the sweep does not extend `clr_busy` beyond 16 cycles.
- Reset at sweep cycle 5: `clr_busy` stays high and the sweep completes 16 cycles after the reset edge.

Source files
------------

// File: rtl/bram_dp_param.sv
// Simple-dual-port block RAM for the NTT datapath: a write port with read-back and an independent read port.
// A built-in clear engine zero-fills (CLR_VAL-fills) the whole array after reset or on request.
module bram_dp_param #(
  parameter int             DW         = 18,
  parameter int             AW         = 12,
  parameter int             RD_MODE    = 0,
  parameter int             OREG       = 0,
  parameter int             CLR_ON_RST = 1,
  parameter logic [DW-1:0]  CLR_VAL    = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_start,
  output logic          clr_busy,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_din,
  output logic [DW-1:0] wr_dout,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dout,
  output logic          rd_valid
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

  logic [DW-1:0] r_mem [DEPTH];

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;

  logic          w_mem_we;
  logic [AW-1:0] w_mem_waddr;
  logic [DW-1:0] w_mem_wdata;

  logic          w_idle;
  logic          w_rd_fire;
  logic          w_rd_hit;
  logic [DW-1:0] w_wr_sample;
  logic [DW-1:0] w_rd_sample;

  logic [DW-1:0] r_wr_dout;
  logic [DW-1:0] r_rd_dout;
  logic          r_rd_valid;

  // The sweep and external writes share one physical write port; the FSM picks the source.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = 1'b0;
    w_mem_waddr = wr_addr;
    w_mem_wdata = wr_din;
    case (r_state)
      ST_IDLE: begin
        w_mem_we = wr_en;
        if (clr_start) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_cnt;
        w_mem_wdata = CLR_VAL;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (r_cnt == {AW{1'b1}}) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign clr_busy = (r_state == ST_CLEAR);

  // Array contents survive reset; only the write is suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (w_mem_we && !rst) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  assign w_idle    = (r_state == ST_IDLE);
  assign w_rd_fire = rd_en & w_idle;
  assign w_rd_hit  = wr_en && (wr_addr == rd_addr);

  // RD_MODE selects whether a same-edge write is bypassed onto the read data.
  assign w_wr_sample = (wr_en && (RD_MODE == 0)) ? wr_din : r_mem[wr_addr];
  assign w_rd_sample = (w_rd_hit && (RD_MODE == 0)) ? wr_din : r_mem[rd_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_dout  <= '0;
      r_rd_dout  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_idle) begin
        r_wr_dout <= w_wr_sample;
      end
      if (w_rd_fire) begin
        r_rd_dout <= w_rd_sample;
      end
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic [DW-1:0] r_wr_dout_q;
      logic [DW-1:0] r_rd_dout_q;
      logic          r_rd_valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_wr_dout_q  <= '0;
          r_rd_dout_q  <= '0;
          r_rd_valid_q <= 1'b0;
        end else begin
          r_wr_dout_q  <= r_wr_dout;
          r_rd_dout_q  <= r_rd_dout;
          r_rd_valid_q <= r_rd_valid;
        end
      end

      assign wr_dout  = r_wr_dout_q;
      assign rd_dout  = r_rd_dout_q;
      assign rd_valid = r_rd_valid_q;
    end else begin : g_no_oreg
      assign wr_dout  = r_wr_dout;
      assign rd_dout  = r_rd_dout;
      assign rd_valid = r_rd_valid;
    end
  endgenerate

  // The counter always wraps back to zero at the end of a sweep, so it idles at zero.
  a_idle_cnt_zero : assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_IDLE) |-> (r_cnt == '0));

  a_no_valid_in_clear : assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_CLEAR) |=> !r_rd_valid);

endmodule

// File: tb/tb_bram_dp_param.sv
// Bench for bram_dp_param: three parameterisations driven by shared stimulus and
// checked every cycle against an array-based reference model, plus directed scenarios.
module tb_bram_dp_param;

  localparam int NI    = 3;
  localparam int DW    = 18;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_start = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_din = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic [DW-1:0] d_wr [NI];
  logic [DW-1:0] d_rd [NI];
  logic          d_busy [NI];
  logic          d_valid [NI];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // u0: write-first, no output reg; u1: read-first, output reg; u2: read-first, no auto clear, nonzero fill
  bram_dp_param #(.DW(DW), .AW(AW), .RD_MODE(0), .OREG(0), .CLR_ON_RST(1), .CLR_VAL(18'h00000)) u0 (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(d_busy[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din), .wr_dout(d_wr[0]),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(d_rd[0]), .rd_valid(d_valid[0]));

  bram_dp_param #(.DW(DW), .AW(AW), .RD_MODE(1), .OREG(1), .CLR_ON_RST(1), .CLR_VAL(18'h00000)) u1 (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(d_busy[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din), .wr_dout(d_wr[1]),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(d_rd[1]), .rd_valid(d_valid[1]));

  bram_dp_param #(.DW(DW), .AW(AW), .RD_MODE(1), .OREG(0), .CLR_ON_RST(0), .CLR_VAL(18'h2A5A5)) u2 (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(d_busy[2]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din), .wr_dout(d_wr[2]),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(d_rd[2]), .rd_valid(d_valid[2]));

  function automatic int p_mode(input int i);
    return (i == 0) ? 0 : 1;
  endfunction
  function automatic bit p_oreg(input int i);
    return (i == 1);
  endfunction
  function automatic bit p_clr(input int i);
    return (i != 2);
  endfunction
  function automatic logic [DW-1:0] p_val(input int i);
    return (i == 2) ? 18'h2A5A5 : 18'h00000;
  endfunction

  // Reference model: array contents with a known flag, sweep progress, and the values
  // visible one edge (e1) and two edges (e2) after they were sampled.
  logic [DW-1:0] m_mem [NI][DEPTH];
  bit            m_kn  [NI][DEPTH];
  bit            m_busy [NI];
  int            m_cnt [NI];
  logic [DW-1:0] e1_wr [NI], e1_rd [NI], e2_wr [NI], e2_rd [NI];
  bit            e1_wk [NI], e1_rk [NI], e2_wk [NI], e2_rk [NI];
  bit            e1_v [NI], e2_v [NI];
  bit            started = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h time=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_busy[i] = p_clr(i);
        m_cnt[i]  = 0;
        e1_wr[i] = '0; e1_rd[i] = '0; e1_wk[i] = 1; e1_rk[i] = 1; e1_v[i] = 0;
        e2_wr[i] = '0; e2_rd[i] = '0; e2_wk[i] = 1; e2_rk[i] = 1; e2_v[i] = 0;
      end else begin
        e2_wr[i] = e1_wr[i]; e2_wk[i] = e1_wk[i];
        e2_rd[i] = e1_rd[i]; e2_rk[i] = e1_rk[i];
        e2_v[i]  = e1_v[i];
        if (m_busy[i]) begin
          m_mem[i][m_cnt[i]] = p_val(i);
          m_kn[i][m_cnt[i]]  = 1;
          e1_v[i] = 0;
          if (m_cnt[i] == DEPTH - 1) m_busy[i] = 0;
          m_cnt[i] = (m_cnt[i] + 1) % DEPTH;
        end else begin
          if (wr_en && p_mode(i) == 0) begin
            e1_wr[i] = wr_din; e1_wk[i] = 1;
          end else begin
            e1_wr[i] = m_mem[i][wr_addr]; e1_wk[i] = m_kn[i][wr_addr];
          end
          e1_v[i] = rd_en;
          if (rd_en) begin
            if (wr_en && wr_addr == rd_addr && p_mode(i) == 0) begin
              e1_rd[i] = wr_din; e1_rk[i] = 1;
            end else begin
              e1_rd[i] = m_mem[i][rd_addr]; e1_rk[i] = m_kn[i][rd_addr];
            end
          end
          if (wr_en) begin
            m_mem[i][wr_addr] = wr_din;
            m_kn[i][wr_addr]  = 1;
          end
          if (clr_start) begin
            m_busy[i] = 1;
            m_cnt[i]  = 0;
          end
        end
      end
    end
    if (rst) started = 1'b1;
  endtask

  task automatic compare_all();
    logic [DW-1:0] xw, xr;
    bit kw, kr, xv;
    if (!started) return;
    for (int i = 0; i < NI; i++) begin
      xw = p_oreg(i) ? e2_wr[i] : e1_wr[i];
      kw = p_oreg(i) ? e2_wk[i] : e1_wk[i];
      xr = p_oreg(i) ? e2_rd[i] : e1_rd[i];
      kr = p_oreg(i) ? e2_rk[i] : e1_rk[i];
      xv = p_oreg(i) ? e2_v[i]  : e1_v[i];
      if (kw) chk($sformatf("u%0d_wr_dout", i), 32'(d_wr[i]), 32'(xw));
      if (kr) chk($sformatf("u%0d_rd_dout", i), 32'(d_rd[i]), 32'(xr));
      chk($sformatf("u%0d_rd_valid", i), 32'(d_valid[i]), 32'(xv));
      chk($sformatf("u%0d_clr_busy", i), 32'(d_busy[i]), 32'(m_busy[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_in();
    clr_start = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int c = 0; c < 40 && d_busy[0]; c++) begin
      n++;
      step();
    end
  endtask

  initial begin
    int busy_n;
    logic [DW-1:0] oreg_exp [3];

    // Reset, then the automatic sweep; u2 gets an explicit clear in the first free cycle.
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    busy_n = 0;
    clr_start = 1'b1;
    for (int c = 0; c < 40 && d_busy[0]; c++) begin
      busy_n++;
      step();
      clr_start = 1'b0;
    end
    chk("rst_busy_len", 32'(busy_n), 32'd16);

    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1;
      rd_addr = 4'(a);
      step();
      chk("clr_rd_data", 32'(d_rd[0]), 32'h0);
      chk("clr_rd_valid", 32'(d_valid[0]), 32'd1);
    end
    idle_in();
    step();

    // Write then read on the next cycle
    wr_en = 1'b1; wr_addr = 4'd3; wr_din = 18'h155AA;
    step();
    idle_in();
    rd_en = 1'b1; rd_addr = 4'd3;
    step();
    chk("wr_then_rd_data", 32'(d_rd[0]), 32'h155AA);
    chk("wr_then_rd_valid", 32'(d_valid[0]), 32'd1);
    idle_in();

    // Same-address collision
    wr_en = 1'b1; wr_addr = 4'd7; wr_din = 18'h00011;
    step();
    wr_en = 1'b1; wr_addr = 4'd7; wr_din = 18'h3FFFF;
    rd_en = 1'b1; rd_addr = 4'd7;
    step();
    chk("coll_wf_rd", 32'(d_rd[0]), 32'h3FFFF);
    chk("coll_wf_wr", 32'(d_wr[0]), 32'h3FFFF);
    chk("coll_rf_rd", 32'(d_rd[2]), 32'h00011);
    chk("coll_rf_wr", 32'(d_wr[2]), 32'h00011);
    idle_in();
    step();
    chk("coll_oreg_rd", 32'(d_rd[1]), 32'h00011);
    chk("coll_oreg_wr", 32'(d_wr[1]), 32'h00011);

    // Output-register pipeline: reads to 1,2,3 back to back
    step();
    step();
    oreg_exp[0] = 18'h0; oreg_exp[1] = 18'h0; oreg_exp[2] = 18'h155AA;
    for (int k = 0; k < 5; k++) begin
      rd_en   = (k < 3);
      rd_addr = 4'(k + 1);
      step();
      chk("oreg_valid", 32'(d_valid[1]), (k >= 1 && k <= 3) ? 32'd1 : 32'd0);
      if (k >= 1 && k <= 3) chk("oreg_data", 32'(d_rd[1]), 32'(oreg_exp[k-1]));
    end
    idle_in();

    // Clear request in the middle of traffic, with a write and a second request during it
    clr_start = 1'b1; rd_en = 1'b1; rd_addr = 4'd0;
    step();
    clr_start = 1'b0;
    busy_n = 0;
    for (int c = 0; c < 40 && d_busy[0]; c++) begin
      busy_n++;
      wr_en = (c == 2); wr_addr = 4'd9; wr_din = 18'h12345;
      rd_en = 1'b1; rd_addr = 4'(c);
      clr_start = (c == 5);
      step();
      chk("sweep_rd_valid", 32'(d_valid[0]), 32'd0);
    end
    chk("sweep_len", 32'(busy_n), 32'd16);
    idle_in();
    rd_en = 1'b1; rd_addr = 4'd9;
    step();
    chk("dropped_wr_u0", 32'(d_rd[0]), 32'h0);
    chk("dropped_wr_u2", 32'(d_rd[2]), 32'h2A5A5);
    idle_in();

    // Reset at sweep cycle 5
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_u2_busy", 32'(d_busy[2]), 32'd0);
    count_busy(busy_n);
    chk("rst_mid_len", 32'(busy_n), 32'd16);

    // Randomized traffic with occasional clears and resets
    for (int n = 0; n < 2000; n++) begin
      rst       = ($urandom_range(0, 499) == 0);
      clr_start = ($urandom_range(0, 149) == 0);
      wr_en     = ($urandom_range(0, 99) < 60);
      wr_addr   = 4'($urandom_range(0, DEPTH - 1));
      wr_din    = 18'($urandom_range(0, 18'h3FFFF));
      rd_en     = ($urandom_range(0, 99) < 60);
      rd_addr   = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, DEPTH - 1));
      step();
    end
    rst = 1'b0;
    idle_in();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
